ace_snoop_initiator: RTL

- Interconnect-side initiator of the ACE snoop channels (AC request, CR response, CD data).
- Broadcasts one coherent snoop transaction to every cache except the originating master.
- Collects the CR responses, forwards the single winning CD cache line and returns a merged snoop summary.
- Sits in the coherency unit in front of the per-core dcache snoop ports.

---
 rtl/ace_snoop_initiator.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
// Interconnect-side ACE snoop initiator. One request is broadcast on the AC
// channel to every cache except the requester. The CR responses are merged
// into a 5-bit summary, the lowest-indexed cache that returns data supplies
// the forwarded CD line, and the summary is then presented on the response
// port.
//
// Handshake rule for every channel (req, AC, CR, CD, data, resp): a beat
// transfers on a rising clk edge where valid and ready are both high. A
// valid never waits for its ready, and once raised it holds with stable
// payload until that transfer edge.
module ace_snoop_initiator #(
    parameter int NR_CACHES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BEATS = 2,
    localparam int SRC_W     = (NR_CACHES > 1) ? $clog2(NR_CACHES) : 1,
    localparam int CNT_W     = $clog2(LINE_BEATS) + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [3:0]                      req_snoop_i,
    input  logic [SRC_W-1:0]                req_src_i,
    output logic [NR_CACHES-1:0]            ac_valid_o,
    input  logic [NR_CACHES-1:0]            ac_ready_i,
    output logic [ADDR_WIDTH-1:0]           ac_addr_o,
    output logic [3:0]                      ac_snoop_o,
    input  logic [NR_CACHES-1:0]            cr_valid_i,
    output logic [NR_CACHES-1:0]            cr_ready_o,
    input  logic [NR_CACHES*5-1:0]          cr_resp_i,
    input  logic [NR_CACHES-1:0]            cd_valid_i,
    output logic [NR_CACHES-1:0]            cd_ready_o,
    input  logic [NR_CACHES*DATA_WIDTH-1:0] cd_data_i,
    input  logic [NR_CACHES-1:0]            cd_last_i,
    output logic                            data_valid_o,
    input  logic                            data_ready_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            data_last_o,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [4:0]                      resp_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    req_ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              snoop_q;
    logic [NR_CACHES-1:0]    pend_ac_q;
    logic [NR_CACHES-1:0]    pend_cr_q;
    logic [NR_CACHES-1:0]    data_mask_q;
    logic [4:0]              acc_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [NR_CACHES-1:0]    target_mask;
    logic [SRC_W-1:0]        winner;
    logic                    cnt_full;
    logic [NR_CACHES-1:0]    ac_hs;
    logic [NR_CACHES-1:0]    cr_hs;
    logic [NR_CACHES-1:0]    cd_hs;
    logic [NR_CACHES-1:0]    pend_ac_d;
    logic [NR_CACHES-1:0]    pend_cr_d;
    logic [NR_CACHES-1:0]    snoop_mask_d;
    logic [4:0]              snoop_acc_d;
    logic [NR_CACHES-1:0]    data_mask_d;
    logic [4:0]              data_acc_d;
    logic [CNT_W-1:0]        cnt_d;

    assign cnt_full = (cnt_q == CNT_W'(LINE_BEATS - 1));

    // Every cache except the requester is snooped.
    always_comb begin
        target_mask            = '1;
        target_mask[req_src_i] = 1'b0;
    end

    // Winner is the lowest-indexed cache still owing data.
    always_comb begin
        winner = '0;
        for (int i = NR_CACHES - 1; i >= 0; i--) begin
            if (data_mask_q[i]) winner = SRC_W'(i);
        end
    end

    // Channel outputs are decoded from the registered state and masks only;
    // the CD path passes the winner straight through to the data port.
    always_comb begin
        ac_valid_o   = '0;
        cr_ready_o   = '0;
        cd_ready_o   = '0;
        data_valid_o = 1'b0;
        data_o       = '0;
        data_last_o  = 1'b0;
        if (state_q == SNOOP) begin
            ac_valid_o = pend_ac_q;
            // CR from a cache is held off until its AC has transferred.
            cr_ready_o = pend_cr_q & ~pend_ac_q;
        end
        if (state_q == DATA) begin
            // Losers are drained unconditionally; the winner follows the sink.
            cd_ready_o         = data_mask_q;
            cd_ready_o[winner] = data_ready_i;
            data_valid_o       = cd_valid_i[winner];
            data_o             = cd_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            data_last_o        = cd_last_i[winner] | cnt_full;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign ac_addr_o    = addr_q;
    assign ac_snoop_o   = snoop_q;
    assign resp_valid_o = (state_q == RESP);
    assign resp_o       = (state_q == RESP) ? acc_q : 5'd0;

    // Snoop phase: retire AC/CR handshakes and merge CR responses.
    always_comb begin
        ac_hs        = ac_valid_o & ac_ready_i;
        cr_hs        = cr_valid_i & cr_ready_o;
        pend_ac_d    = pend_ac_q & ~ac_hs;
        pend_cr_d    = pend_cr_q & ~cr_hs;
        snoop_mask_d = data_mask_q;
        snoop_acc_d  = acc_q;
        for (int i = 0; i < NR_CACHES; i++) begin
            if (cr_hs[i]) begin
                snoop_acc_d[4:1] = snoop_acc_d[4:1] | cr_resp_i[i*5+1 +: 4];
                if (cr_resp_i[i*5]) begin
                    snoop_mask_d[i] = 1'b1;
                    snoop_acc_d[0]  = 1'b1;
                end
            end
        end
    end

    // Data phase: retire finished lines and guard the winner's line length.
    always_comb begin
        cd_hs       = cd_valid_i & cd_ready_o;
        data_mask_d = data_mask_q;
        data_acc_d  = acc_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < NR_CACHES; i++) begin
            if (cd_hs[i] && cd_last_i[i] && (SRC_W'(i) != winner)) data_mask_d[i] = 1'b0;
        end
        if (cd_hs[winner]) begin
            if (data_last_o) begin
                data_mask_d[winner] = 1'b0;
                cnt_d               = '0;
                // A line that overruns LINE_BEATS is cut short and flagged.
                if (!cd_last_i[winner]) data_acc_d[1] = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Transaction FSM with all sequencing registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            snoop_q     <= '0;
            pend_ac_q   <= '0;
            pend_cr_q   <= '0;
            data_mask_q <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        addr_q      <= req_addr_i;
                        snoop_q     <= req_snoop_i;
                        pend_ac_q   <= target_mask;
                        pend_cr_q   <= target_mask;
                        data_mask_q <= '0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= SNOOP;
                    end
                end
                SNOOP: begin
                    pend_ac_q   <= pend_ac_d;
                    pend_cr_q   <= pend_cr_d;
                    data_mask_q <= snoop_mask_d;
                    acc_q       <= snoop_acc_d;
                    if (pend_cr_d == '0) begin
                        state_q <= (snoop_mask_d != '0) ? DATA : RESP;
                    end
                end
                DATA: begin
                    data_mask_q <= data_mask_d;
                    acc_q       <= data_acc_d;
                    cnt_q       <= cnt_d;
                    if (data_mask_d == '0) state_q <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
